// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the ID/EX register.
// The slave modport is the stage itself; master is whatever drives ID/MEM/WB and consumes EX.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OP_W   = 4
);
   logic              i_Stall;
   logic              i_Flush;
   logic              i_ID_Valid;
   logic [DATA_W-1:0] i_ID_RsData;
   logic [DATA_W-1:0] i_ID_RtData;
   logic [DATA_W-1:0] i_ID_Imm;
   logic [4:0]        i_ID_Shamt;
   logic [REG_AW-1:0] i_ID_Rs;
   logic [REG_AW-1:0] i_ID_Rt;
   logic [REG_AW-1:0] i_ID_Rd;
   logic [OP_W-1:0]   i_ID_ALUOp;
   logic              i_ID_ALUSrc1;
   logic              i_ID_ALUSrc2;
   logic              i_ID_RegWrite;
   logic              i_ID_MemRead;
   logic              i_ID_MemWrite;
   logic              i_ID_MemToReg;
   logic              i_MEM_RegWrite;
   logic [REG_AW-1:0] i_MEM_Rd;
   logic [DATA_W-1:0] i_MEM_Result;
   logic              i_WB_RegWrite;
   logic [REG_AW-1:0] i_WB_Rd;
   logic [DATA_W-1:0] i_WB_Data;

   logic [DATA_W-1:0] o_ALU_In1;
   logic [DATA_W-1:0] o_ALU_In2;
   logic [OP_W-1:0]   o_ALUOp;
   logic [DATA_W-1:0] o_StoreData;
   logic              o_Valid;
   logic [REG_AW-1:0] o_Rd;
   logic              o_RegWrite;
   logic              o_MemRead;
   logic              o_MemWrite;
   logic              o_MemToReg;
   logic              o_LoadUse;

   modport slave (
      input  i_Stall, i_Flush, i_ID_Valid, i_ID_RsData, i_ID_RtData, i_ID_Imm,
             i_ID_Shamt, i_ID_Rs, i_ID_Rt, i_ID_Rd, i_ID_ALUOp, i_ID_ALUSrc1,
             i_ID_ALUSrc2, i_ID_RegWrite, i_ID_MemRead, i_ID_MemWrite, i_ID_MemToReg,
             i_MEM_RegWrite, i_MEM_Rd, i_MEM_Result, i_WB_RegWrite, i_WB_Rd, i_WB_Data,
      output o_ALU_In1, o_ALU_In2, o_ALUOp, o_StoreData, o_Valid, o_Rd, o_RegWrite,
             o_MemRead, o_MemWrite, o_MemToReg, o_LoadUse
   );

   modport master (
      output i_Stall, i_Flush, i_ID_Valid, i_ID_RsData, i_ID_RtData, i_ID_Imm,
             i_ID_Shamt, i_ID_Rs, i_ID_Rt, i_ID_Rd, i_ID_ALUOp, i_ID_ALUSrc1,
             i_ID_ALUSrc2, i_ID_RegWrite, i_ID_MemRead, i_ID_MemWrite, i_ID_MemToReg,
             i_MEM_RegWrite, i_MEM_Rd, i_MEM_Result, i_WB_RegWrite, i_WB_Rd, i_WB_Data,
      input  o_ALU_In1, o_ALU_In2, o_ALUOp, o_StoreData, o_Valid, o_Rd, o_RegWrite,
             o_MemRead, o_MemWrite, o_MemToReg, o_LoadUse
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU source select,
// stall/flush handling and load-use hazard detection.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OP_W   = 4
) (
   input logic          i_Clk,
   input logic          i_Rst_n,
   id_ex_stage_if.slave bus
);

   logic              valid_q,    valid_d;
   logic [DATA_W-1:0] rs_data_q,  rs_data_d;
   logic [DATA_W-1:0] rt_data_q,  rt_data_d;
   logic [DATA_W-1:0] imm_q,      imm_d;
   logic [4:0]        shamt_q,    shamt_d;
   logic [REG_AW-1:0] rs_q,       rs_d;
   logic [REG_AW-1:0] rt_q,       rt_d;
   logic [REG_AW-1:0] rd_q,       rd_d;
   logic [OP_W-1:0]   aluop_q,    aluop_d;
   logic              alusrc1_q,  alusrc1_d;
   logic              alusrc2_q,  alusrc2_d;
   logic              regwrite_q, regwrite_d;
   logic              memread_q,  memread_d;
   logic              memwrite_q, memwrite_d;
   logic              memtoreg_q, memtoreg_d;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Register $0 never forwards; the younger MEM result beats WB.
   always_comb begin
      fwd_rs = rs_data_q;
      if (bus.i_MEM_RegWrite && (rs_q != '0) && (bus.i_MEM_Rd == rs_q))
         fwd_rs = bus.i_MEM_Result;
      else if (bus.i_WB_RegWrite && (rs_q != '0) && (bus.i_WB_Rd == rs_q))
         fwd_rs = bus.i_WB_Data;
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (bus.i_MEM_RegWrite && (rt_q != '0) && (bus.i_MEM_Rd == rt_q))
         fwd_rt = bus.i_MEM_Result;
      else if (bus.i_WB_RegWrite && (rt_q != '0) && (bus.i_WB_Rd == rt_q))
         fwd_rt = bus.i_WB_Data;
   end

   always_comb begin
      valid_d    = valid_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      shamt_d    = shamt_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      aluop_d    = aluop_q;
      alusrc1_d  = alusrc1_q;
      alusrc2_d  = alusrc2_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      memtoreg_d = memtoreg_q;

      if (bus.i_Flush) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         memtoreg_d = 1'b0;
      end else if (bus.i_Stall) begin
         // Capture forwarded operands so they outlive the producer leaving MEM/WB.
         rs_data_d = fwd_rs;
         rt_data_d = fwd_rt;
      end else begin
         valid_d    = bus.i_ID_Valid;
         rs_data_d  = bus.i_ID_RsData;
         rt_data_d  = bus.i_ID_RtData;
         imm_d      = bus.i_ID_Imm;
         shamt_d    = bus.i_ID_Shamt;
         rs_d       = bus.i_ID_Rs;
         rt_d       = bus.i_ID_Rt;
         rd_d       = bus.i_ID_Rd;
         aluop_d    = bus.i_ID_ALUOp;
         alusrc1_d  = bus.i_ID_ALUSrc1;
         alusrc2_d  = bus.i_ID_ALUSrc2;
         // Side-effect bits are masked for bubbles so an invalid slot can never write.
         regwrite_d = bus.i_ID_RegWrite & bus.i_ID_Valid;
         memread_d  = bus.i_ID_MemRead  & bus.i_ID_Valid;
         memwrite_d = bus.i_ID_MemWrite & bus.i_ID_Valid;
         memtoreg_d = bus.i_ID_MemToReg & bus.i_ID_Valid;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         valid_q    <= 1'b0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         shamt_q    <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         aluop_q    <= '0;
         alusrc1_q  <= 1'b0;
         alusrc2_q  <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         shamt_q    <= shamt_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         aluop_q    <= aluop_d;
         alusrc1_q  <= alusrc1_d;
         alusrc2_q  <= alusrc2_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
      end
   end

   assign bus.o_ALU_In1   = alusrc1_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
   assign bus.o_ALU_In2   = alusrc2_q ? imm_q : fwd_rt;
   assign bus.o_StoreData = fwd_rt;
   assign bus.o_ALUOp     = aluop_q;
   assign bus.o_Valid     = valid_q;
   assign bus.o_Rd        = rd_q;
   assign bus.o_RegWrite  = regwrite_q;
   assign bus.o_MemRead   = memread_q;
   assign bus.o_MemWrite  = memwrite_q;
   assign bus.o_MemToReg  = memtoreg_q;

   assign bus.o_LoadUse = valid_q & memread_q & bus.i_ID_Valid & (rd_q != '0) &
                          ((rd_q == bus.i_ID_Rs) | (rd_q == bus.i_ID_Rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, $0, source muxes,
// stall/flush and load-use detection, with hand-computed expectations.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .OP_W(4)) bus ();

   id_ex_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_id(input logic valid, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [3:0] op, input logic src1, input logic src2,
                          input logic [4:0] sh, input logic [31:0] imm,
                          input logic rw, input logic mr);
      bus.i_ID_Valid    = valid;
      bus.i_ID_Rs       = rs;
      bus.i_ID_RsData   = rsd;
      bus.i_ID_Rt       = rt;
      bus.i_ID_RtData   = rtd;
      bus.i_ID_Rd       = rd;
      bus.i_ID_ALUOp    = op;
      bus.i_ID_ALUSrc1  = src1;
      bus.i_ID_ALUSrc2  = src2;
      bus.i_ID_Shamt    = sh;
      bus.i_ID_Imm      = imm;
      bus.i_ID_RegWrite = rw;
      bus.i_ID_MemRead  = mr;
      bus.i_ID_MemWrite = 1'b0;
      bus.i_ID_MemToReg = mr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_Stall = 0; bus.i_Flush = 0;
      load_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.i_MEM_RegWrite = 1; bus.i_MEM_Rd = 5'd3; bus.i_MEM_Result = 32'h1234;
      bus.i_WB_RegWrite  = 1; bus.i_WB_Rd  = 5'd3; bus.i_WB_Data    = 32'h5678;

      // Reset: everything zero, live MEM/WB inputs cannot leak through index 0
      step(); step();
      chk("rst_valid", {31'b0, bus.o_Valid}, 0);
      chk("rst_in1",   bus.o_ALU_In1, 0);
      chk("rst_in2",   bus.o_ALU_In2, 0);
      chk("rst_store", bus.o_StoreData, 0);
      chk("rst_aluop", {28'b0, bus.o_ALUOp}, 0);
      chk("rst_rw",    {31'b0, bus.o_RegWrite}, 0);

      // First load after release: one-edge latency
      bus.i_MEM_RegWrite = 0; bus.i_WB_RegWrite = 0;
      rst_n = 1;
      load_id(1, 5'd3, 32'd5, 5'd6, 32'h66, 5'd8, 4'd2, 0, 0, 0, 0, 1, 0);
      chk("lat_pre_valid", {31'b0, bus.o_Valid}, 0);
      step();
      chk("load_valid", {31'b0, bus.o_Valid}, 1);
      chk("load_rd",    {27'b0, bus.o_Rd}, 8);
      chk("load_aluop", {28'b0, bus.o_ALUOp}, 2);
      chk("load_rw",    {31'b0, bus.o_RegWrite}, 1);
      chk("load_in1",   bus.o_ALU_In1, 5);
      chk("load_in2",   bus.o_ALU_In2, 32'h66);

      // Forwarding priority MEM > WB > register
      bus.i_MEM_RegWrite = 1; bus.i_MEM_Rd = 5'd3; bus.i_MEM_Result = 32'h10;
      bus.i_WB_RegWrite  = 1; bus.i_WB_Rd  = 5'd3; bus.i_WB_Data    = 32'h20;
      #1 chk("fwd_mem", bus.o_ALU_In1, 32'h10);
      bus.i_MEM_RegWrite = 0;
      #1 chk("fwd_wb", bus.o_ALU_In1, 32'h20);
      bus.i_WB_Rd = 5'd6;
      #1 chk("fwd_none_rs", bus.o_ALU_In1, 5);
      chk("fwd_wb_rt_in2",   bus.o_ALU_In2, 32'h20);
      chk("fwd_wb_rt_store", bus.o_StoreData, 32'h20);
      bus.i_WB_RegWrite = 0;

      // $0 is never forwarded
      load_id(1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 4'd0, 0, 0, 0, 0, 1, 0);
      step();
      bus.i_MEM_RegWrite = 1; bus.i_MEM_Rd = 5'd0; bus.i_MEM_Result = 32'hFF;
      bus.i_WB_RegWrite  = 1; bus.i_WB_Rd  = 5'd0; bus.i_WB_Data    = 32'hEE;
      #1 chk("zero_in1",   bus.o_ALU_In1, 0);
      chk("zero_store", bus.o_StoreData, 0);
      bus.i_WB_RegWrite = 0;

      // Source select
      load_id(1, 5'd3, 32'd5, 5'd6, 32'h66, 5'd2, 4'd9, 1, 1, 5'd7, 32'hFFFF_FFFC, 1, 0);
      step();
      chk("src_in1",   bus.o_ALU_In1, 7);
      chk("src_in2",   bus.o_ALU_In2, 32'hFFFF_FFFC);
      chk("src_aluop", {28'b0, bus.o_ALUOp}, 9);
      chk("src_store", bus.o_StoreData, 32'h66);
      bus.i_MEM_Rd = 5'd6; bus.i_MEM_Result = 32'h77;
      #1 chk("src_store_fwd", bus.o_StoreData, 32'h77);
      chk("src_in2_imm", bus.o_ALU_In2, 32'hFFFF_FFFC);
      bus.i_MEM_RegWrite = 0;

      // Stall: forwarded rs value survives the producer retiring
      load_id(1, 5'd3, 32'd5, 5'd6, 32'h66, 5'd11, 4'd5, 0, 0, 0, 0, 1, 0);
      step();
      bus.i_MEM_RegWrite = 1; bus.i_MEM_Rd = 5'd3; bus.i_MEM_Result = 32'hAB;
      bus.i_Stall = 1;
      load_id(1, 5'd9, 32'h99, 5'd10, 32'hAA, 5'd12, 4'd1, 0, 0, 0, 0, 0, 0);
      #1 chk("stall_fwd", bus.o_ALU_In1, 32'hAB);
      step();
      bus.i_MEM_RegWrite = 0;
      bus.i_WB_RegWrite = 1; bus.i_WB_Rd = 5'd3; bus.i_WB_Data = 32'hAB;
      #1 chk("stall_c1_in1", bus.o_ALU_In1, 32'hAB);
      step();
      bus.i_WB_RegWrite = 0;
      #1 chk("stall_c2_in1", bus.o_ALU_In1, 32'hAB);
      step();
      chk("stall_c3_in1",   bus.o_ALU_In1, 32'hAB);
      chk("stall_c3_aluop", {28'b0, bus.o_ALUOp}, 5);
      chk("stall_c3_rd",    {27'b0, bus.o_Rd}, 11);
      chk("stall_c3_valid", {31'b0, bus.o_Valid}, 1);
      bus.i_Flush = 1;
      step();
      chk("flush_valid", {31'b0, bus.o_Valid}, 0);
      chk("flush_rw",    {31'b0, bus.o_RegWrite}, 0);
      bus.i_Flush = 0; bus.i_Stall = 0;

      // Load-use
      load_id(1, 5'd1, 32'd0, 5'd2, 32'd0, 5'd4, 4'd0, 0, 1, 0, 32'd4, 1, 1);
      step();
      chk("lw_memread", {31'b0, bus.o_MemRead}, 1);
      load_id(1, 5'd1, 32'd0, 5'd4, 32'd0, 5'd7, 4'd0, 0, 0, 0, 0, 1, 0);
      #1 chk("lu_rt", {31'b0, bus.o_LoadUse}, 1);
      bus.i_ID_Rt = 5'd0;
      #1 chk("lu_rt0", {31'b0, bus.o_LoadUse}, 0);
      bus.i_ID_Rs = 5'd4;
      #1 chk("lu_rs", {31'b0, bus.o_LoadUse}, 1);
      bus.i_ID_Valid = 0;
      #1 chk("lu_idinvalid", {31'b0, bus.o_LoadUse}, 0);
      bus.i_ID_Valid = 1; bus.i_Flush = 1;
      step();
      bus.i_Flush = 0;
      chk("lu_exinvalid", {31'b0, bus.o_LoadUse}, 0);
      load_id(1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 4'd0, 0, 1, 0, 32'd0, 1, 1);
      step();
      #1 chk("lu_rd0", {31'b0, bus.o_LoadUse}, 0);

      // Asynchronous reset mid-stream
      load_id(1, 5'd3, 32'h33, 5'd6, 32'h66, 5'd9, 4'd3, 0, 0, 0, 0, 1, 0);
      step();
      chk("pre_rst_valid", {31'b0, bus.o_Valid}, 1);
      #2 rst_n = 0;
      #1 chk("arst_valid", {31'b0, bus.o_Valid}, 0);
      chk("arst_rw",  {31'b0, bus.o_RegWrite}, 0);
      chk("arst_in1", bus.o_ALU_In1, 0);
      chk("arst_rd",  {27'b0, bus.o_Rd}, 0);
      step();
      rst_n = 1;
      chk("arst_hold_valid", {31'b0, bus.o_Valid}, 0);
      step();
      chk("post_rst_valid", {31'b0, bus.o_Valid}, 1);
      chk("post_rst_in1",   bus.o_ALU_In1, 32'h33);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
